// File: rtl/op_identifier.sv
// Identifies which operation an external select-driven 2-input logic unit
// performs by sweeping all operand vectors and decoding the captured truth table.
module op_identifier #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic resp,
  output logic probe_a,
  output logic probe_b,
  output logic busy,
  output logic done,
  output logic S1,
  output logic S0,
  output logic valid_op,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          // capture edge: record response for this vector, move to the next
          tt_d[idx_q] = resp;
          cnt_d       = '0;
          idx_d       = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DECODE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        valid_d = 1'b1;
        err_d   = 1'b0;
        case (tt_q)
          4'b0110: sel_d = 2'b00;
          4'b1110: sel_d = 2'b01;
          4'b1000: sel_d = 2'b10;
          4'b0111: sel_d = 2'b11;
          default: begin
            sel_d   = 2'b00;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign probe_a  = (state_q == DRIVE) & idx_q[1];
  assign probe_b  = (state_q == DRIVE) & idx_q[0];
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign S1       = sel_q[1];
  assign S0       = sel_q[0];
  assign valid_op = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_op_identifier.sv
// Self-checking bench for op_identifier: one instance with SETTLE=1 and a
// combinational unit model, one with SETTLE=3 and a 2-cycle delayed response.
module tb_op_identifier;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [3:0] tt_model = 4'b0000;

  logic pa1, pb1, busy1, done1, s1_1, s0_1, valid1, err1, resp1, start1;
  logic pa2, pb2, busy2, done2, s1_2, s0_2, valid2, err2, resp2, start2;
  logic d1 = 1'b0, d2 = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_code = 2'b00;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign resp1  = tt_model[{pa1, pb1}];
  assign resp2  = d2;

  always @(posedge clk) begin
    d1 <= tt_model[{pa2, pb2}];
    d2 <= d1;
  end

  op_identifier #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .resp(resp1),
    .probe_a(pa1), .probe_b(pb1), .busy(busy1), .done(done1),
    .S1(s1_1), .S0(s0_1), .valid_op(valid1), .err(err1)
  );

  op_identifier #(.SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .resp(resp2),
    .probe_a(pa2), .probe_b(pb2), .busy(busy2), .done(done2),
    .S1(s1_2), .S0(s0_2), .valid_op(valid2), .err(err2)
  );

  logic obs_pa, obs_pb, obs_busy, obs_done, obs_s1, obs_s0, obs_valid, obs_err;
  assign obs_pa    = sel ? pa2    : pa1;
  assign obs_pb    = sel ? pb2    : pb1;
  assign obs_busy  = sel ? busy2  : busy1;
  assign obs_done  = sel ? done2  : done1;
  assign obs_s1    = sel ? s1_2   : s1_1;
  assign obs_s0    = sel ? s0_2   : s0_1;
  assign obs_valid = sel ? valid2 : valid1;
  assign obs_err   = sel ? err2   : err1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: build each known operation's truth table from its boolean rule.
  task automatic ref_decode(input logic [3:0] tt, output logic [1:0] code, output logic v);
    code = 2'b00;
    v    = 1'b0;
    for (int op = 0; op < 4; op++) begin
      logic [3:0] t;
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) begin
          int r;
          case (op)
            0: r = a ^ b;
            1: r = a | b;
            2: r = a & b;
            default: r = 1 - (a & b);
          endcase
          t[a * 2 + b] = r[0];
        end
      if (t == tt) begin
        code = 2'(op);
        v    = 1'b1;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_all"}, {obs_pa, obs_pb, obs_busy, obs_done, obs_s1, obs_s0, obs_valid, obs_err}, 8'h00);
  endtask

  task automatic chk_held(input string tag);
    chk(tag, 8'({obs_s1, obs_s0, obs_valid, obs_err}), 8'({exp_code, exp_valid, exp_err}));
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle when start is held).
  task automatic run(input logic [3:0] tt, input bit keep, input bit poke);
    int unsigned s_len;
    logic [1:0] code;
    logic v;
    s_len = sel ? 3 : 1;
    tt_model = tt;
    start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned s = 0; s < s_len; s++) begin
        if (poke && i == 1 && s == 0) start = 1'b1;
        chk("probe_vec", 8'({obs_pa, obs_pb}), 8'(i));
        chk("busy_drive", 8'(obs_busy), 8'd1);
        chk("done_drive", 8'(obs_done), 8'd0);
        chk_held("held_drive");
        @(negedge clk);
        if (poke && !keep) start = 1'b0;
      end
    chk("probe_decode", 8'({obs_pa, obs_pb}), 8'd0);
    chk("busy_decode", 8'(obs_busy), 8'd1);
    chk("done_decode", 8'(obs_done), 8'd0);
    chk_held("held_decode");
    @(negedge clk);
    ref_decode(tt, code, v);
    exp_code  = code;
    exp_valid = v;
    exp_err   = ~v;
    chk("done_pulse", 8'(obs_done), 8'd1);
    chk("busy_done", 8'(obs_busy), 8'd0);
    chk_held("result");
    if (!keep) begin
      @(negedge clk);
      chk("done_once", 8'(obs_done), 8'd0);
      chk("busy_after", 8'(obs_busy), 8'd0);
      chk_held("result_hold");
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset_held");

    // first start on the first edge after release; AND -> 10
    rst_n = 1'b1;
    run(4'b1000, 1'b0, 1'b0);

    // back-to-back with start held: xor, or, and, nand
    run(4'b0110, 1'b1, 1'b0);
    run(4'b1110, 1'b1, 1'b0);
    run(4'b1000, 1'b1, 1'b0);
    run(4'b0111, 1'b0, 1'b0);

    // resp tied high -> no match
    run(4'b1111, 1'b0, 1'b0);

    // start pulsed mid-run is ignored
    run(4'b0111, 1'b0, 1'b1);

    // reset during vector 10 of an xor run
    tt_model = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("probe_before_rst", 8'({obs_pa, obs_pb}), 8'd2);
    rst_n = 1'b0;
    #1 chk_zero("reset_midrun");
    @(negedge clk);
    chk_zero("reset_midrun_held");
    exp_code  = 2'b00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_release");
    run(4'b0110, 1'b0, 1'b0);

    // random truth tables
    for (int k = 0; k < 12; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      run(r, 1'b0, 1'b0);
    end

    // SETTLE=3 instance, nand with 2-cycle delayed response
    sel = 1'b1;
    exp_code  = 2'b00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    @(negedge clk);
    chk_zero("settle3_idle");
    run(4'b0111, 1'b0, 1'b0);
    run(4'b1110, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
